// File: rtl/vga_timing_ctrl_if.sv
// Scan-address / pixel / pin bundle of the VGA timing generator.
// master = timing generator, slave = vga_drive plus pin consumer.
interface vga_timing_ctrl_if;
  logic [15:0] rgb_data;
  logic [31:0] ram_data_in;
  logic [11:0] addr_h;
  logic [11:0] addr_v;
  logic        data_req;
  logic [31:0] ram_data_frame;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        vga_de;
  logic [15:0] vga_rgb;

  modport master (
    input  rgb_data, ram_data_in,
    output addr_h, addr_v, data_req, ram_data_frame, frame_start,
           hsync, vsync, vga_de, vga_rgb
  );

  modport slave (
    output rgb_data, ram_data_in,
    input  addr_h, addr_v, data_req, ram_data_frame, frame_start,
           hsync, vsync, vga_de, vga_rgb
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: free-running h/v counters, scan-address issue,
// two-stage sync/DE alignment to the returned pixel, and per-frame word latch.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  vga_timing_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
  localparam logic [11:0] H_DE_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_DE_END = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_DE_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_DE_END = 12'(V_SYNC + V_BACK + V_ACTIVE);

  logic [11:0] r_cnt_h;
  logic [11:0] r_cnt_v;
  logic        w_h_wrap;
  logic        w_v_wrap;

  logic        w_hs0;
  logic        w_vs0;
  logic        w_de0;

  logic        r_hs_d1, r_hs_d2;
  logic        r_vs_d1, r_vs_d2;
  logic        r_de_d1, r_de_d2;
  logic [15:0] r_rgb;
  logic [31:0] r_frame;

  assign w_h_wrap = (r_cnt_h == H_LAST);
  assign w_v_wrap = (r_cnt_v == V_LAST);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (w_h_wrap) begin
      r_cnt_h <= '0;
      r_cnt_v <= w_v_wrap ? '0 : r_cnt_v + 12'd1;
    end else begin
      r_cnt_h <= r_cnt_h + 12'd1;
    end
  end

  // Stage 0: everything here is decoded straight from the counters.
  assign w_hs0 = (r_cnt_h < H_SYNC_W);
  assign w_vs0 = (r_cnt_v < V_SYNC_W);
  assign w_de0 = (r_cnt_h >= H_DE_BEG) && (r_cnt_h < H_DE_END) &&
                 (r_cnt_v >= V_DE_BEG) && (r_cnt_v < V_DE_END);

  assign bus.data_req    = w_de0;
  assign bus.addr_h      = w_de0 ? (r_cnt_h - H_DE_BEG) : '0;
  assign bus.addr_v      = w_de0 ? (r_cnt_v - V_DE_BEG) : '0;
  assign bus.frame_start = (r_cnt_h == '0) && (r_cnt_v == '0);

  // d1 lines up with the pixel returned by vga_drive, d2 with the pin register.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d1 <= 1'b0;
      r_hs_d2 <= 1'b0;
      r_vs_d1 <= 1'b0;
      r_vs_d2 <= 1'b0;
      r_de_d1 <= 1'b0;
      r_de_d2 <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_hs_d1 <= w_hs0;
      r_hs_d2 <= r_hs_d1;
      r_vs_d1 <= w_vs0;
      r_vs_d2 <= r_vs_d1;
      r_de_d1 <= w_de0;
      r_de_d2 <= r_de_d1;
      r_rgb   <= r_de_d1 ? bus.rgb_data : '0;
    end
  end

  // Latched on the first front-porch line so the word never changes mid-picture.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if ((r_cnt_h == '0) && (r_cnt_v == V_DE_END)) begin
      r_frame <= bus.ram_data_in;
    end
  end

  assign bus.hsync          = r_hs_d2 ^ ~SYNC_POL;
  assign bus.vsync          = r_vs_d2 ^ ~SYNC_POL;
  assign bus.vga_de         = r_de_d2;
  assign bus.vga_rgb        = r_rgb;
  assign bus.ram_data_frame = r_frame;

endmodule
